// File: rtl/eco32f_pkg.sv
// Shared types and widths for the ECO32F Wishbone arbiter and its watchdog.
package eco32f_pkg;

    localparam int unsigned WB_AW  = 32;
    localparam int unsigned WB_DW  = 32;
    localparam int unsigned WB_SW  = 4;
    localparam int unsigned WB_CTW = 3;
    localparam int unsigned WB_BTW = 2;
    localparam int unsigned WDOG_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    // Master-to-slave request payload, one per master port.
    typedef struct packed {
        logic [WB_AW-1:0]  adr;
        logic [WB_DW-1:0]  dat;
        logic [WB_SW-1:0]  sel;
        logic [WB_CTW-1:0] cti;
        logic [WB_BTW-1:0] bte;
        logic              stb;
        logic              cyc;
        logic              we;
    } wb_req_t;

endpackage

// File: rtl/eco32f_wb_watchdog.sv
// Slave-silence counter: counts stalled strobe cycles and flags when LIMIT is reached.
module eco32f_wb_watchdog
    import eco32f_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WDOG_W-1:0] count;

    // Clear has priority; otherwise count while the strobe is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expire = (count == WDOG_W'(LIMIT));

endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Two-master (instruction fetch / load-store) Wishbone arbiter with round-robin
// tie-break and a slave-silence timeout that aborts the stuck cycle.
module eco32f_wb_arbiter
    import eco32f_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch master
    input  logic [WB_AW-1:0]    iwbm_adr_i,
    input  logic [WB_DW-1:0]    iwbm_dat_i,
    input  logic                iwbm_stb_i,
    input  logic                iwbm_cyc_i,
    input  logic                iwbm_we_i,
    input  logic [WB_SW-1:0]    iwbm_sel_i,
    input  logic [WB_CTW-1:0]   iwbm_cti_i,
    input  logic [WB_BTW-1:0]   iwbm_bte_i,
    output logic                iwbm_ack_o,
    output logic                iwbm_err_o,
    output logic                iwbm_rty_o,
    output logic [WB_DW-1:0]    iwbm_dat_o,
    // load/store master
    input  logic [WB_AW-1:0]    dwbm_adr_i,
    input  logic [WB_DW-1:0]    dwbm_dat_i,
    input  logic                dwbm_stb_i,
    input  logic                dwbm_cyc_i,
    input  logic                dwbm_we_i,
    input  logic [WB_SW-1:0]    dwbm_sel_i,
    input  logic [WB_CTW-1:0]   dwbm_cti_i,
    input  logic [WB_BTW-1:0]   dwbm_bte_i,
    output logic                dwbm_ack_o,
    output logic                dwbm_err_o,
    output logic                dwbm_rty_o,
    output logic [WB_DW-1:0]    dwbm_dat_o,
    // shared slave bus
    output logic [WB_AW-1:0]    wbm_adr_o,
    output logic [WB_DW-1:0]    wbm_dat_o,
    output logic [WB_SW-1:0]    wbm_sel_o,
    output logic [WB_CTW-1:0]   wbm_cti_o,
    output logic [WB_BTW-1:0]   wbm_bte_o,
    output logic                wbm_stb_o,
    output logic                wbm_cyc_o,
    output logic                wbm_we_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    input  logic                wbm_rty_i,
    input  logic [WB_DW-1:0]    wbm_dat_i,
    output logic                grant_d
);

    arb_state_e state, state_next;
    logic       last_d;
    wb_req_t    ireq, dreq, gnt_req;
    logic       slave_resp, expire, abort, wdog_clear;
    logic       gnt_i, gnt_d;

    assign ireq = '{adr: iwbm_adr_i, dat: iwbm_dat_i, sel: iwbm_sel_i, cti: iwbm_cti_i,
                    bte: iwbm_bte_i, stb: iwbm_stb_i, cyc: iwbm_cyc_i, we: iwbm_we_i};
    assign dreq = '{adr: dwbm_adr_i, dat: dwbm_dat_i, sel: dwbm_sel_i, cti: dwbm_cti_i,
                    bte: dwbm_bte_i, stb: dwbm_stb_i, cyc: dwbm_cyc_i, we: dwbm_we_i};

    // Grant state and round-robin memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ST_GNT_D) begin
                last_d <= 1'b1;
            end else if (state_next == ST_GNT_I) begin
                last_d <= 1'b0;
            end
        end
    end

    // Next grant: hold while owner keeps cyc, hand over directly, tie-break on last_d.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (dwbm_cyc_i && (!iwbm_cyc_i || !last_d)) begin
                    state_next = ST_GNT_D;
                end else if (iwbm_cyc_i) begin
                    state_next = ST_GNT_I;
                end
            end
            ST_GNT_I: begin
                if (!iwbm_cyc_i) begin
                    state_next = dwbm_cyc_i ? ST_GNT_D : ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!dwbm_cyc_i) begin
                    state_next = iwbm_cyc_i ? ST_GNT_I : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Select the granted master's request; IDLE presents an all-zero bus.
    always_comb begin
        gnt_req = '0;
        case (state)
            ST_GNT_I: gnt_req = ireq;
            ST_GNT_D: gnt_req = dreq;
            default:  gnt_req = '0;
        endcase
    end

    assign gnt_i      = (state == ST_GNT_I);
    assign gnt_d      = (state == ST_GNT_D);
    assign slave_resp = wbm_ack_i | wbm_err_i | wbm_rty_i;
    // Any slave response in the expiry cycle wins over the timeout.
    assign abort      = expire & gnt_req.stb & ~slave_resp;
    assign wdog_clear = slave_resp | ~gnt_req.stb | (state_next != state) | abort;

    eco32f_wb_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wdog_clear),
        .enable (gnt_req.stb),
        .expire (expire)
    );

    assign wbm_adr_o = gnt_req.adr;
    assign wbm_dat_o = gnt_req.dat;
    assign wbm_sel_o = gnt_req.sel;
    assign wbm_cti_o = gnt_req.cti;
    assign wbm_bte_o = gnt_req.bte;
    assign wbm_we_o  = gnt_req.we;
    assign wbm_stb_o = gnt_req.stb & ~abort;
    assign wbm_cyc_o = gnt_req.cyc & ~abort;

    assign iwbm_ack_o = gnt_i & wbm_ack_i;
    assign iwbm_err_o = gnt_i & (wbm_err_i | abort);
    assign iwbm_rty_o = gnt_i & wbm_rty_i;
    assign dwbm_ack_o = gnt_d & wbm_ack_i;
    assign dwbm_err_o = gnt_d & (wbm_err_i | abort);
    assign dwbm_rty_o = gnt_d & wbm_rty_i;

    assign iwbm_dat_o = wbm_dat_i;
    assign dwbm_dat_o = wbm_dat_i;
    assign grant_d    = gnt_d;

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Randomized bench for eco32f_wb_arbiter: master drivers push expected responses,
// a negedge monitor checks every bus cycle against an ownership model and pops
// the response scoreboard.
module tb_eco32f_wb_arbiter;

    localparam int unsigned TMO      = 4;
    localparam logic [31:0] DATA_KEY = 32'h1111_1111;
    localparam logic [1:0]  K_ACK    = 2'd0;
    localparam logic [1:0]  K_ERR    = 2'd1;
    localparam logic [1:0]  K_RTY    = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    logic        clk, rst_n;
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_bte [2];

    logic        iwbm_ack_o, iwbm_err_o, iwbm_rty_o;
    logic        dwbm_ack_o, dwbm_err_o, dwbm_rty_o;
    logic [31:0] iwbm_dat_o, dwbm_dat_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_stb_o, wbm_cyc_o, wbm_we_o, grant_d;
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_dat;

    int   checks = 0;
    int   errors = 0;
    int   fix_lat;
    exp_t q_i[$];
    exp_t q_d[$];

    eco32f_wb_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst_n),
        .iwbm_adr_i(m_adr[0]), .iwbm_dat_i(m_wdat[0]), .iwbm_stb_i(m_stb[0]),
        .iwbm_cyc_i(m_cyc[0]), .iwbm_we_i(m_we[0]), .iwbm_sel_i(m_sel[0]),
        .iwbm_cti_i(m_cti[0]), .iwbm_bte_i(m_bte[0]),
        .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o), .iwbm_rty_o(iwbm_rty_o),
        .iwbm_dat_o(iwbm_dat_o),
        .dwbm_adr_i(m_adr[1]), .dwbm_dat_i(m_wdat[1]), .dwbm_stb_i(m_stb[1]),
        .dwbm_cyc_i(m_cyc[1]), .dwbm_we_i(m_we[1]), .dwbm_sel_i(m_sel[1]),
        .dwbm_cti_i(m_cti[1]), .dwbm_bte_i(m_bte[1]),
        .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o), .dwbm_rty_o(dwbm_rty_o),
        .dwbm_dat_o(dwbm_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_we_o(wbm_we_o),
        .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty), .wbm_dat_i(s_dat),
        .grant_d(grant_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Slave address flags: bit29 = never answers, bit28 = answers with retry.
    function automatic logic [31:0] rand_adr(input logic sil, input logic rt);
        logic [31:0] lo;
        lo = $urandom;
        return {2'b00, sil, rt, lo[27:16], lo[15:8], 8'h00};
    endfunction

    // Slave model: random 0..4 cycle latency (or fix_lat), data = adr + key.
    initial begin
        logic        busy;
        int          left, lat;
        logic [31:0] s_adr;
        logic        n_ack, n_rty;
        busy = 1'b0; left = 0; s_adr = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
        forever begin
            @(posedge clk);
            #2;
            n_ack = 1'b0; n_rty = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (left == 0) begin
                    busy  = 1'b0;
                    n_rty = s_adr[28];
                    n_ack = !s_adr[28];
                    s_dat = s_adr + DATA_KEY;
                end else if (!(wbm_cyc_o && wbm_stb_o)) begin
                    busy = 1'b0;
                end else begin
                    left--;
                end
            end else if (wbm_cyc_o && wbm_stb_o && !wbm_adr_o[29]) begin
                s_adr = wbm_adr_o;
                lat   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
                if (lat == 0) begin
                    n_rty = s_adr[28];
                    n_ack = !s_adr[28];
                    s_dat = s_adr + DATA_KEY;
                end else begin
                    busy = 1'b1;
                    left = lat - 1;
                end
            end
            s_ack = n_ack;
            s_rty = n_rty;
            s_err = 1'b0;
        end
    end

    // One master transaction (single or burst); stops on non-ack or reset.
    task automatic run_txn(input int m, input int beats, input logic [31:0] adr0, input logic we);
        logic [31:0] a;
        logic        got, ok;
        int          budget;
        exp_t        e;
        a = adr0;
        @(posedge clk);
        #1;
        for (int b = 0; b < beats; b++) begin
            if (b > 0) begin
                @(posedge clk);
                #1;
            end
            e.kind = a[29] ? K_ERR : (a[28] ? K_RTY : K_ACK);
            e.we   = we;
            e.dat  = a + DATA_KEY;
            if (m == 0) q_i.push_back(e); else q_d.push_back(e);
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_adr[m] = a;
            m_wdat[m] = $urandom; m_sel[m] = 4'hF; m_bte[m] = 2'b00;
            m_cti[m] = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
            got = 1'b0; ok = 1'b0; budget = 400;
            while (!got && budget > 0 && rst_n) begin
                @(negedge clk);
                got = (m == 0) ? (iwbm_ack_o | iwbm_err_o | iwbm_rty_o)
                               : (dwbm_ack_o | dwbm_err_o | dwbm_rty_o);
                ok  = (m == 0) ? iwbm_ack_o : dwbm_ack_o;
                budget--;
            end
            if (!rst_n) break;
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL response_wait m=%0d actual=no_response required=response", m);
                break;
            end
            if (!ok) break;
            a = a + 32'd4;
        end
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_cti[m] = 3'b000;
    endtask

    task automatic rand_txn(input int m);
        int   beats;
        logic sil, rt;
        beats = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 8)) : 1;
        sil   = ($urandom_range(0, 7) == 0);
        rt    = !sil && ($urandom_range(0, 7) == 0);
        run_txn(m, beats, rand_adr(sil, rt), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic score(input int m, input logic ack, input logic err, input logic [31:0] dat);
        exp_t       e;
        logic [1:0] k;
        k = ack ? K_ACK : (err ? K_ERR : K_RTY);
        if ((m == 0 && q_i.size() == 0) || (m == 1 && q_d.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response m=%0d actual=kind%0d required=none", m, k);
        end else begin
            e = (m == 0) ? q_i.pop_front() : q_d.pop_front();
            check($sformatf("resp_kind_m%0d", m), 256'(k), 256'(e.kind));
            if (k == K_ACK && !e.we) begin
                check($sformatf("read_data_m%0d", m), 256'(dat), 256'(e.dat));
            end
        end
    endtask

    // Reference ownership model: 0 none, 1 iwbm, 2 dwbm.
    int          m_owner, m_last, m_cnt, nxt;
    logic [31:0] o_adr, o_dat;
    logic [3:0]  o_sel;
    logic [2:0]  o_cti;
    logic [1:0]  o_bte;
    logic        o_stb, o_cyc, o_we, resp, abort, gi, gd;
    logic [146:0] act_vec, exp_vec;

    always @(negedge clk) begin
        act_vec = {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_stb_o,
                   wbm_cyc_o, wbm_we_o, iwbm_ack_o, iwbm_err_o, iwbm_rty_o,
                   dwbm_ack_o, dwbm_err_o, dwbm_rty_o, grant_d, iwbm_dat_o, dwbm_dat_o};
        if (!rst_n) begin
            m_owner = 0; m_last = 0; m_cnt = 0;
            q_i.delete();
            q_d.delete();
            check("reset_outputs", 256'(act_vec), 256'({83'd0, s_dat, s_dat}));
        end else begin
            if (m_owner != 0) begin
                o_adr = m_adr[m_owner-1]; o_dat = m_wdat[m_owner-1]; o_sel = m_sel[m_owner-1];
                o_cti = m_cti[m_owner-1]; o_bte = m_bte[m_owner-1]; o_stb = m_stb[m_owner-1];
                o_cyc = m_cyc[m_owner-1]; o_we = m_we[m_owner-1];
            end else begin
                o_adr = '0; o_dat = '0; o_sel = '0; o_cti = '0; o_bte = '0;
                o_stb = 1'b0; o_cyc = 1'b0; o_we = 1'b0;
            end
            gi    = (m_owner == 1);
            gd    = (m_owner == 2);
            resp  = s_ack | s_err | s_rty;
            abort = o_stb && (m_cnt == int'(TMO)) && !resp;
            exp_vec = {o_adr, o_dat, o_sel, o_cti, o_bte, o_stb & !abort, o_cyc & !abort, o_we,
                       gi & s_ack, gi & (s_err | abort), gi & s_rty,
                       gd & s_ack, gd & (s_err | abort), gd & s_rty, gd, s_dat, s_dat};
            check("bus_cycle", 256'(act_vec), 256'(exp_vec));
            if (iwbm_ack_o | iwbm_err_o | iwbm_rty_o) score(0, iwbm_ack_o, iwbm_err_o, iwbm_dat_o);
            if (dwbm_ack_o | dwbm_err_o | dwbm_rty_o) score(1, dwbm_ack_o, dwbm_err_o, dwbm_dat_o);
            if (m_owner != 0 && m_cyc[m_owner-1]) begin
                nxt = m_owner;
            end else if (m_cyc[0] && m_cyc[1]) begin
                nxt = (m_last == 1) ? 1 : 2;
            end else if (m_cyc[1]) begin
                nxt = 2;
            end else if (m_cyc[0]) begin
                nxt = 1;
            end else begin
                nxt = 0;
            end
            m_cnt = (nxt != m_owner || !o_stb || resp || abort) ? 0 : m_cnt + 1;
            if (nxt == 2) m_last = 1;
            else if (nxt == 1) m_last = 0;
            m_owner = nxt;
        end
    end

    initial begin
        int n, bud;
        rst_n = 1'b0;
        fix_lat = -1;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_wdat[m] = '0; m_stb[m] = 1'b0; m_cyc[m] = 1'b0;
            m_we[m] = 1'b0; m_sel[m] = '0; m_cti[m] = '0; m_bte[m] = '0;
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // both masters request together: dwbm first, then iwbm without idle
        fork
            run_txn(0, 1, rand_adr(1'b0, 1'b0), 1'b0);
            run_txn(1, 1, rand_adr(1'b0, 1'b0), 1'b1);
        join

        // iwbm single read, ack two cycles after strobe
        fix_lat = 2;
        run_txn(0, 1, 32'h0123_4567, 1'b0);

        // ack landing on the timeout cycle must win
        fix_lat = 4;
        run_txn(1, 1, rand_adr(1'b0, 1'b0), 1'b0);
        fix_lat = -1;

        // iwbm 8-beat burst while dwbm waits
        fork
            run_txn(0, 8, rand_adr(1'b0, 1'b0), 1'b0);
            begin
                @(posedge clk);
                run_txn(1, 1, rand_adr(1'b0, 1'b0), 1'b0);
            end
        join

        // silent slave: dwbm aborted with err
        run_txn(1, 1, rand_adr(1'b1, 1'b0), 1'b0);

        // back-to-back alternating singles from both masters
        fork
            for (int t = 0; t < 10; t++) run_txn(0, 1, rand_adr(1'b0, 1'b0), 1'b0);
            for (int t = 0; t < 10; t++) run_txn(1, 1, rand_adr(1'b0, 1'b0), 1'b1);
        join

        // randomized mix of singles, bursts, retries and timeouts
        fork
            for (int t = 0; t < 15; t++) rand_txn(0);
            for (int t = 0; t < 15; t++) rand_txn(1);
        join

        // reset during beat 3 of a dbus burst
        fix_lat = 1;
        fork
            run_txn(1, 8, rand_adr(1'b0, 1'b0), 1'b0);
            begin
                n = 0; bud = 200;
                while (n < 2 && bud > 0) begin
                    @(negedge clk);
                    if (dwbm_ack_o) n++;
                    bud--;
                end
                check("burst_acks_before_reset", 256'(n), 256'(2));
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("reset_immediate", 256'({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o,
                      wbm_bte_o, wbm_stb_o, wbm_cyc_o, wbm_we_o, iwbm_ack_o, iwbm_err_o,
                      iwbm_rty_o, dwbm_ack_o, dwbm_err_o, dwbm_rty_o, grant_d}), 256'(0));
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
            end
        join
        fix_lat = -1;

        // first arbitration after reset release
        run_txn(0, 2, rand_adr(1'b0, 1'b0), 1'b0);

        repeat (4) @(posedge clk);
        check("queue_i_drained", 256'(q_i.size()), 256'(0));
        check("queue_d_drained", 256'(q_d.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
